bg_pixel_fetcher: RTL

BG_PIXEL_FETCHER -- requirements
Module: bg_pixel_fetcher

---
 rtl/bg_pixel_fetcher_pkg.sv | 51 +++++
 rtl/bg_pixel_fifo.sv | 42 ++++
 rtl/bg_pixel_fetcher.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bg_pixel_fetcher_pkg.sv
// Shared video definitions for the background pixel fetcher: fetch FSM
// states, VRAM layout constants and address / pixel packing helpers.
package bg_pixel_fetcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAP0 = 3'd1,
        ST_MAP1 = 3'd2,
        ST_LO0  = 3'd3,
        ST_LO1  = 3'd4,
        ST_HI0  = 3'd5,
        ST_HI1  = 3'd6,
        ST_PUSH = 3'd7
    } fetch_state_t;

    // Background tile maps start at 0x1800; the second map sits one stride higher.
    localparam logic [12:0] VRAM_MAP_BASE   = 13'h1800;
    localparam logic [12:0] VRAM_MAP_STRIDE = 13'h0400;

    // Tile-map entry address for a 32x32 map: row from line_y[7:3], column from col.
    function automatic logic [12:0] map_addr(input logic       map_sel,
                                             input logic [7:0] line_y,
                                             input logic [4:0] col);
        logic [12:0] stride;
        stride = map_sel ? VRAM_MAP_STRIDE : 13'h0000;
        return VRAM_MAP_BASE | stride | {3'b000, line_y[7:3], 5'b00000} | {8'h00, col};
    endfunction

    // Tile pattern address. With tile_sel=0 tile numbers are signed around 0x1000,
    // so bit 12 is set only for tiles 0x00-0x7F.
    function automatic logic [12:0] tile_data_addr(input logic       tile_sel,
                                                   input logic [7:0] tile,
                                                   input logic [2:0] row,
                                                   input logic       plane);
        logic b12;
        b12 = ~tile_sel & ~tile[7];
        return {b12, tile, row, plane};
    endfunction

    // Pack one tile row into 8 two-bit pixels; pixel 0 (leftmost) in bits [1:0].
    function automatic logic [15:0] pack_pixels(input logic [7:0] lo,
                                                input logic [7:0] hi);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            p[2*i +: 2] = {hi[7-i], lo[7-i]};
        end
        return p;
    endfunction

endpackage

// File: rtl/bg_pixel_fifo.sv
// Eight-entry, 2-bit pixel shift register: parallel load of a full tile row,
// single pixel pop from the head, and an occupancy count.
module bg_pixel_fifo
(
    input  logic        clkpipe,
    input  logic        nreset_video,
    input  logic        flush,
    input  logic        load,
    input  logic [15:0] load_pix,
    input  logic        pop,
    output logic [1:0]  head,
    output logic [3:0]  count
);

    logic [15:0] data_r;
    logic [3:0]  count_r;

    // Pixel storage and count; a load always refills all eight slots, which
    // also covers the case where the last pixel pops on the same edge.
    always_ff @(posedge clkpipe or negedge nreset_video) begin
        if (!nreset_video) begin
            data_r  <= 16'h0000;
            count_r <= 4'd0;
        end else if (flush) begin
            data_r  <= 16'h0000;
            count_r <= 4'd0;
        end else if (load) begin
            data_r  <= load_pix;
            count_r <= 4'd8;
        end else if (pop && (count_r != 4'd0)) begin
            data_r  <= {2'b00, data_r[15:2]};
            count_r <= count_r - 4'd1;
        end else begin
            data_r  <= data_r;
            count_r <= count_r;
        end
    end

    assign head  = data_r[1:0];
    assign count = count_r;

endmodule

// File: rtl/bg_pixel_fetcher.sv
// Background pixel fetcher: walks the tile map and tile patterns for the
// current line, feeds an 8-pixel FIFO and streams one pixel per clock while
// rendering, dropping the first scx[2:0] pixels for fine horizontal scroll.
module bg_pixel_fetcher
    import bg_pixel_fetcher_pkg::*;
(
    input  logic        clkpipe,
    input  logic        nreset_video,
    input  logic        render,
    input  logic [7:0]  v,
    input  logic [7:0]  scy,
    input  logic [7:0]  scx,
    input  logic        bg_map_sel,
    input  logic        bg_tile_sel,
    output logic [12:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    output logic [1:0]  pix,
    output logic        pix_valid
);

    fetch_state_t state_r, state_s;
    logic [4:0]   col_r, col_s;
    logic [7:0]   tile_r, lo_r, hi_r;
    logic [2:0]   disc_r;
    logic         armed_r;
    logic [12:0]  vram_addr_r, addr_s;
    logic         vram_rd_r, rd_s;
    logic [1:0]   pix_r;
    logic         pix_valid_r;

    logic [7:0]   line_y_s;
    logic [2:0]   row_s;
    logic [7:0]   tile_s;
    logic         pop_s;
    logic         push_ok_s;
    logic         load_s;
    logic [15:0]  load_pix_s;
    logic [1:0]   fifo_head_s;
    logic [3:0]   fifo_count_s;

    bg_pixel_fifo u_fifo (
        .clkpipe      (clkpipe),
        .nreset_video (nreset_video),
        .flush        (~render),
        .load         (load_s),
        .load_pix     (load_pix_s),
        .pop          (pop_s),
        .head         (fifo_head_s),
        .count        (fifo_count_s)
    );

    // Line/row selection and FIFO handshake; scroll and line inputs are used live.
    always_comb begin
        line_y_s   = v + scy;
        row_s      = line_y_s[2:0];
        tile_s     = (state_r == ST_MAP1) ? vram_data : tile_r;
        pop_s      = render && (fifo_count_s != 4'd0);
        push_ok_s  = (fifo_count_s == 4'd0) || ((fifo_count_s == 4'd1) && pop_s);
        load_s     = render && (state_r == ST_PUSH) && push_ok_s;
        load_pix_s = pack_pixels(lo_r, hi_r);
    end

    // Fetch FSM next state and map column; render low always aborts to IDLE.
    always_comb begin
        state_s = state_r;
        col_s   = col_r;
        if (!render) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (armed_r) begin
                        state_s = ST_MAP0;
                        col_s   = scx[7:3];
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MAP0: state_s = ST_MAP1;
                ST_MAP1: state_s = ST_LO0;
                ST_LO0:  state_s = ST_LO1;
                ST_LO1:  state_s = ST_HI0;
                ST_HI0:  state_s = ST_HI1;
                ST_HI1:  state_s = ST_PUSH;
                ST_PUSH: begin
                    if (push_ok_s) begin
                        state_s = ST_MAP0;
                        col_s   = col_r + 5'd1;
                    end else begin
                        state_s = ST_PUSH;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // VRAM request for the cycle being entered; address holds between reads.
    always_comb begin
        addr_s = vram_addr_r;
        rd_s   = 1'b0;
        case (state_s)
            ST_MAP0: begin
                addr_s = map_addr(bg_map_sel, line_y_s, col_s);
                rd_s   = 1'b1;
            end
            ST_LO0: begin
                addr_s = tile_data_addr(bg_tile_sel, tile_s, row_s, 1'b0);
                rd_s   = 1'b1;
            end
            ST_HI0: begin
                addr_s = tile_data_addr(bg_tile_sel, tile_s, row_s, 1'b1);
                rd_s   = 1'b1;
            end
            default: begin
                addr_s = vram_addr_r;
                rd_s   = 1'b0;
            end
        endcase
    end

    // FSM state and column registers.
    always_ff @(posedge clkpipe or negedge nreset_video) begin
        if (!nreset_video) begin
            state_r <= ST_IDLE;
            col_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
        end
    end

    // Start permission: a window may begin only after render has been seen low,
    // so a reset released mid-line waits for the next line.
    always_ff @(posedge clkpipe or negedge nreset_video) begin
        if (!nreset_video) begin
            armed_r <= 1'b0;
        end else if (!render) begin
            armed_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && armed_r) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Capture read data one cycle after each read strobe.
    always_ff @(posedge clkpipe or negedge nreset_video) begin
        if (!nreset_video) begin
            tile_r <= 8'h00;
            lo_r   <= 8'h00;
            hi_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_MAP1: tile_r <= vram_data;
                ST_LO1:  lo_r   <= vram_data;
                ST_HI1:  hi_r   <= vram_data;
                default: begin
                    tile_r <= tile_r;
                    lo_r   <= lo_r;
                    hi_r   <= hi_r;
                end
            endcase
        end
    end

    // Registered VRAM request outputs.
    always_ff @(posedge clkpipe or negedge nreset_video) begin
        if (!nreset_video) begin
            vram_addr_r <= 13'h0000;
            vram_rd_r   <= 1'b0;
        end else begin
            vram_addr_r <= addr_s;
            vram_rd_r   <= rd_s;
        end
    end

    // Pixel output with fine-scroll discard of the first scx[2:0] pops.
    always_ff @(posedge clkpipe or negedge nreset_video) begin
        if (!nreset_video) begin
            pix_r       <= 2'b00;
            pix_valid_r <= 1'b0;
            disc_r      <= 3'd0;
        end else if (!render) begin
            pix_r       <= pix_r;
            pix_valid_r <= 1'b0;
            disc_r      <= 3'd0;
        end else if (pop_s) begin
            pix_r <= fifo_head_s;
            if (disc_r < scx[2:0]) begin
                pix_valid_r <= 1'b0;
                disc_r      <= disc_r + 3'd1;
            end else begin
                pix_valid_r <= 1'b1;
                disc_r      <= disc_r;
            end
        end else begin
            pix_r       <= pix_r;
            pix_valid_r <= 1'b0;
            disc_r      <= disc_r;
        end
    end

    assign vram_addr = vram_addr_r;
    assign vram_rd   = vram_rd_r;
    assign pix       = pix_r;
    assign pix_valid = pix_valid_r;

endmodule
